// File: rtl/tod_counter_chain.sv
// Time-of-day core: sec/min/hour counters with one-cycle ripple carry,
// parallel load, per-field adjust, 12/24h display and alarm compare.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   tick_en         : 1 Hz strobe, advances seconds (with carry)
//   adj_sel/inc/dec : manual +/-1 on one field, no carry
//   load, load_*    : parallel load, rejected if any field out of range
//   mode_12h        : 12h display select
//   alarm_en/_min/_hour : alarm compare setup
//   sec/min/hour    : registered time
//   hour_disp, pm   : display hour and PM flag (combinational)
//   day_carry       : pulse on full-day rollover
//   alarm_hit       : pulse when a tick lands on alarm time
//   load_err        : pulse when a load is rejected
module tod_counter_chain #(
  parameter  int SEC_MOD  = 60,
  parameter  int MIN_MOD  = 60,
  parameter  int HOUR_MOD = 24,
  localparam int SW = $clog2(SEC_MOD),
  localparam int MW = $clog2(MIN_MOD),
  localparam int HW = $clog2(HOUR_MOD)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick_en,
  input  logic [1:0]    adj_sel,
  input  logic          adj_inc,
  input  logic          adj_dec,
  input  logic          load,
  input  logic [SW-1:0] load_sec,
  input  logic [MW-1:0] load_min,
  input  logic [HW-1:0] load_hour,
  input  logic          mode_12h,
  input  logic          alarm_en,
  input  logic [MW-1:0] alarm_min,
  input  logic [HW-1:0] alarm_hour,
  output logic [SW-1:0] sec,
  output logic [MW-1:0] min,
  output logic [HW-1:0] hour,
  output logic [HW-1:0] hour_disp,
  output logic          pm,
  output logic          day_carry,
  output logic          alarm_hit,
  output logic          load_err
);

  localparam logic [SW-1:0] S_MAX = SW'(SEC_MOD - 1);
  localparam logic [MW-1:0] M_MAX = MW'(MIN_MOD - 1);
  localparam logic [HW-1:0] H_MAX = HW'(HOUR_MOD - 1);

  logic [SW-1:0] s_cur, s_inc, s_dec, s_nxt;
  logic [MW-1:0] m_cur, m_inc, m_dec, m_nxt;
  logic [HW-1:0] h_cur, h_inc, h_dec, h_nxt;
  logic          s_wrap, m_wrap, h_wrap;
  logic          load_ok, adj_go;
  logic          dc_nxt, ah_nxt, le_nxt;
  logic [31:0]   hour_w, disp_w;

  // Out-of-range fields are treated as zero so they self-heal next edge.
  assign s_cur = (sec  > S_MAX) ? '0 : sec;
  assign m_cur = (min  > M_MAX) ? '0 : min;
  assign h_cur = (hour > H_MAX) ? '0 : hour;

  assign s_wrap = (s_cur == S_MAX);
  assign m_wrap = (m_cur == M_MAX);
  assign h_wrap = (h_cur == H_MAX);

  assign s_inc = s_wrap ? '0 : s_cur + SW'(1);
  assign m_inc = m_wrap ? '0 : m_cur + MW'(1);
  assign h_inc = h_wrap ? '0 : h_cur + HW'(1);

  assign s_dec = (s_cur == '0) ? S_MAX : s_cur - SW'(1);
  assign m_dec = (m_cur == '0) ? M_MAX : m_cur - MW'(1);
  assign h_dec = (h_cur == '0) ? H_MAX : h_cur - HW'(1);

  assign load_ok = (load_sec  <= S_MAX) &&
                   (load_min  <= M_MAX) &&
                   (load_hour <= H_MAX);

  assign adj_go = (adj_sel != 2'd3) && (adj_inc ^ adj_dec);

  always_comb begin
    s_nxt  = s_cur;
    m_nxt  = m_cur;
    h_nxt  = h_cur;
    dc_nxt = 1'b0;
    ah_nxt = 1'b0;
    le_nxt = 1'b0;
    if (load) begin
      if (load_ok) begin
        s_nxt = load_sec;
        m_nxt = load_min;
        h_nxt = load_hour;
      end else begin
        le_nxt = 1'b1;
      end
    end else if (tick_en) begin
      s_nxt = s_inc;
      if (s_wrap) begin
        m_nxt = m_inc;
        if (m_wrap) begin
          h_nxt  = h_inc;
          dc_nxt = h_wrap;
        end
      end
      ah_nxt = alarm_en && (s_nxt == '0) &&
               (m_nxt == alarm_min) &&
               (h_nxt == alarm_hour);
    end else if (adj_go) begin
      case (adj_sel)
        2'd0:    s_nxt = adj_inc ? s_inc : s_dec;
        2'd1:    m_nxt = adj_inc ? m_inc : m_dec;
        2'd2:    h_nxt = adj_inc ? h_inc : h_dec;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sec       <= '0;
      min       <= '0;
      hour      <= '0;
      day_carry <= 1'b0;
      alarm_hit <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      sec       <= s_nxt;
      min       <= m_nxt;
      hour      <= h_nxt;
      day_carry <= dc_nxt;
      alarm_hit <= ah_nxt;
      load_err  <= le_nxt;
    end
  end

  // 12h mapping: 0 -> 12, 13..23 -> 1..11.
  always_comb begin
    hour_w = 32'(hour);
    disp_w = hour_w;
    if (mode_12h) begin
      if (hour_w == 32'd0)
        disp_w = 32'd12;
      else if (hour_w > 32'd12)
        disp_w = hour_w - 32'd12;
    end
  end

  assign hour_disp = HW'(disp_w);
  assign pm        = (hour_w >= 32'd12);

endmodule

// File: tb/tb_tod_counter_chain.sv
// Bench for tod_counter_chain: directed vector table, full-day run,
// randomized traffic against a seconds-of-day model, small-modulus wrap.
module tb_tod_counter_chain;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, tick_en, adj_inc, adj_dec, load;
  logic       mode_12h, alarm_en;
  logic [1:0] adj_sel;
  logic [5:0] load_sec, load_min, alarm_min, sec, min;
  logic [4:0] load_hour, alarm_hour, hour, hour_disp;
  logic       pm, day_carry, alarm_hit, load_err;

  logic       rst_s, tick_s;
  logic [3:0] sec_s;
  logic [2:0] min_s;
  logic [1:0] hour_s, hd_s;
  logic       pm_s, dc_s, ah_s, le_s;

  tod_counter_chain dut (
    .clk(clk), .rst(rst), .tick_en(tick_en),
    .adj_sel(adj_sel), .adj_inc(adj_inc), .adj_dec(adj_dec),
    .load(load), .load_sec(load_sec), .load_min(load_min),
    .load_hour(load_hour), .mode_12h(mode_12h),
    .alarm_en(alarm_en), .alarm_min(alarm_min),
    .alarm_hour(alarm_hour), .sec(sec), .min(min), .hour(hour),
    .hour_disp(hour_disp), .pm(pm), .day_carry(day_carry),
    .alarm_hit(alarm_hit), .load_err(load_err)
  );

  tod_counter_chain #(.SEC_MOD(10), .MIN_MOD(6), .HOUR_MOD(4)) dut_s (
    .clk(clk), .rst(rst_s), .tick_en(tick_s),
    .adj_sel(2'd3), .adj_inc(1'b0), .adj_dec(1'b0),
    .load(1'b0), .load_sec(4'd0), .load_min(3'd0),
    .load_hour(2'd0), .mode_12h(1'b0),
    .alarm_en(1'b0), .alarm_min(3'd0),
    .alarm_hour(2'd0), .sec(sec_s), .min(min_s), .hour(hour_s),
    .hour_disp(hd_s), .pm(pm_s), .day_carry(dc_s),
    .alarm_hit(ah_s), .load_err(le_s)
  );

  typedef struct {
    int r, t, l, ls, lm, lh, sel, inc, dec, m12, aen;
    int es, em, eh, ehd, epm, edc, eah, ele;
  } vec_t;

  vec_t tbl[30];

  int nvec = 0;
  int nbad = 0;

  // Model state: seconds since midnight plus expected pulse flags.
  int mt = 0;
  int e_dc = 0, e_ah = 0, e_le = 0;

  function automatic vec_t mkv(
    input int r, t, l, ls, lm, lh, sel, inc, dec, m12, aen,
    input int es, em, eh, ehd, epm, edc, eah, ele);
    vec_t v;
    v.r = r; v.t = t; v.l = l; v.ls = ls; v.lm = lm; v.lh = lh;
    v.sel = sel; v.inc = inc; v.dec = dec; v.m12 = m12; v.aen = aen;
    v.es = es; v.em = em; v.eh = eh; v.ehd = ehd;
    v.epm = epm; v.edc = edc; v.eah = eah; v.ele = ele;
    return v;
  endfunction

  function automatic int disp(input int h, input int m12);
    if (m12 == 0) return h;
    if (h == 0) return 12;
    if (h > 12) return h - 12;
    return h;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_step();
    e_dc = 0; e_ah = 0; e_le = 0;
    if (rst) begin
      mt = 0;
    end else if (load) begin
      if (int'(load_sec) < 60 && int'(load_min) < 60 &&
          int'(load_hour) < 24)
        mt = int'(load_hour) * 3600 + int'(load_min) * 60 +
             int'(load_sec);
      else
        e_le = 1;
    end else if (tick_en) begin
      mt = (mt + 1) % 86400;
      e_dc = (mt == 0) ? 1 : 0;
      e_ah = (alarm_en && mt == int'(alarm_hour) * 3600 +
              int'(alarm_min) * 60) ? 1 : 0;
    end else if (adj_sel != 2'd3 && (adj_inc ^ adj_dec)) begin
      int s, m, h, d;
      s = mt % 60; m = (mt / 60) % 60; h = mt / 3600;
      d = adj_inc ? 1 : -1;
      case (adj_sel)
        2'd0: s = (s + d + 60) % 60;
        2'd1: m = (m + d + 60) % 60;
        default: h = (h + d + 24) % 24;
      endcase
      mt = h * 3600 + m * 60 + s;
    end
  endtask

  task automatic check_model();
    int h;
    h = mt / 3600;
    chk("sec", int'(sec), mt % 60);
    chk("min", int'(min), (mt / 60) % 60);
    chk("hour", int'(hour), h);
    chk("hour_disp", int'(hour_disp), disp(h, int'(mode_12h)));
    chk("pm", int'(pm), (h >= 12) ? 1 : 0);
    chk("day_carry", int'(day_carry), e_dc);
    chk("alarm_hit", int'(alarm_hit), e_ah);
    chk("load_err", int'(load_err), e_le);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rst = 1'b0; tick_en = 1'b0; load = 1'b0;
    adj_sel = 2'd3; adj_inc = 1'b0; adj_dec = 1'b0;
    load_sec = '0; load_min = '0; load_hour = '0;
    mode_12h = 1'b0; alarm_en = 1'b0;
    alarm_min = 6'd30; alarm_hour = 5'd7;
  endtask

  task automatic apply_vec(input vec_t v);
    rst = 1'(v.r); tick_en = 1'(v.t); load = 1'(v.l);
    load_sec = 6'(v.ls); load_min = 6'(v.lm); load_hour = 5'(v.lh);
    adj_sel = 2'(v.sel); adj_inc = 1'(v.inc); adj_dec = 1'(v.dec);
    mode_12h = 1'(v.m12); alarm_en = 1'(v.aen);
  endtask

  initial begin
    // r t l  ls lm lh sel i d m12 aen | s  m  h  hd pm dc ah le
    tbl[0]  = mkv(1,0,0, 0, 0, 0,3,0,0,0,0,  0, 0, 0, 0,0,0,0,0);
    tbl[1]  = mkv(0,0,1,56,34,12,3,0,0,0,0, 56,34,12,12,1,0,0,0);
    tbl[2]  = mkv(0,0,1,60, 1, 1,3,0,0,0,0, 56,34,12,12,1,0,0,1);
    tbl[3]  = mkv(0,0,0, 0, 0, 0,3,0,0,0,0, 56,34,12,12,1,0,0,0);
    tbl[4]  = mkv(0,0,1, 0, 0,10,3,0,0,0,0,  0, 0,10,10,0,0,0,0);
    tbl[5]  = mkv(0,0,0, 0, 0, 0,1,0,1,0,0,  0,59,10,10,0,0,0,0);
    tbl[6]  = mkv(0,0,1,59,59,10,3,0,0,0,0, 59,59,10,10,0,0,0,0);
    tbl[7]  = mkv(0,0,0, 0, 0, 0,0,1,0,0,0,  0,59,10,10,0,0,0,0);
    tbl[8]  = mkv(0,0,1, 7, 6, 5,3,0,0,0,0,  7, 6, 5, 5,0,0,0,0);
    tbl[9]  = mkv(0,1,0, 0, 0, 0,2,1,0,0,0,  8, 6, 5, 5,0,0,0,0);
    tbl[10] = mkv(0,1,1, 3, 2, 1,3,0,0,0,0,  3, 2, 1, 1,0,0,0,0);
    tbl[11] = mkv(0,0,1,59,29, 7,3,0,0,0,1, 59,29, 7, 7,0,0,0,0);
    tbl[12] = mkv(0,1,0, 0, 0, 0,3,0,0,0,1,  0,30, 7, 7,0,0,1,0);
    tbl[13] = mkv(0,0,0, 0, 0, 0,3,0,0,0,1,  0,30, 7, 7,0,0,0,0);
    tbl[14] = mkv(0,0,1,59,29, 7,3,0,0,0,0, 59,29, 7, 7,0,0,0,0);
    tbl[15] = mkv(0,1,0, 0, 0, 0,3,0,0,0,0,  0,30, 7, 7,0,0,0,0);
    tbl[16] = mkv(0,0,1, 0,30, 7,3,0,0,0,1,  0,30, 7, 7,0,0,0,0);
    tbl[17] = mkv(0,0,1, 0, 0, 0,3,0,0,1,0,  0, 0, 0,12,0,0,0,0);
    tbl[18] = mkv(0,0,1, 0, 0,12,3,0,0,1,0,  0, 0,12,12,1,0,0,0);
    tbl[19] = mkv(0,0,1, 0, 0,23,3,0,0,1,0,  0, 0,23,11,1,0,0,0);
    tbl[20] = mkv(0,0,1, 0, 0,13,3,0,0,1,0,  0, 0,13, 1,1,0,0,0);
    tbl[21] = mkv(0,1,1,59,59,23,3,0,0,0,0, 59,59,23,23,1,0,0,0);
    tbl[22] = mkv(0,1,0, 0, 0, 0,3,0,0,0,0,  0, 0, 0, 0,0,1,0,0);
    tbl[23] = mkv(0,0,0, 0, 0, 0,3,0,0,0,0,  0, 0, 0, 0,0,0,0,0);
    tbl[24] = mkv(0,0,0, 0, 0, 0,0,0,1,0,0, 59, 0, 0, 0,0,0,0,0);
    tbl[25] = mkv(0,0,0, 0, 0, 0,2,0,1,0,0, 59, 0,23,23,1,0,0,0);
    tbl[26] = mkv(0,0,0, 0, 0, 0,3,1,0,0,0, 59, 0,23,23,1,0,0,0);
    tbl[27] = mkv(0,0,0, 0, 0, 0,1,1,1,0,0, 59, 0,23,23,1,0,0,0);
    tbl[28] = mkv(1,1,1, 5, 5, 5,0,1,0,0,0,  0, 0, 0, 0,0,0,0,0);
    tbl[29] = mkv(0,0,1, 0, 0,24,3,0,0,0,0,  0, 0, 0, 0,0,0,0,1);

    idle_in();
    rst_s = 1'b1; tick_s = 1'b0;

    // Reset, then a full day of ticks.
    rst = 1'b1;
    repeat (4) begin cyc(); check_model(); end
    chk("reset.sec", int'(sec), 0);
    chk("reset.hour", int'(hour), 0);
    rst = 1'b0;
    tick_en = 1'b1;
    repeat (86398) begin cyc(); check_model(); end
    chk("day.sec", int'(sec), 58);
    chk("day.min", int'(min), 59);
    chk("day.hour", int'(hour), 23);
    cyc(); check_model();
    chk("day.pre_dc", int'(day_carry), 0);
    cyc(); check_model();
    chk("day.wrap_sec", int'(sec), 0);
    chk("day.wrap_hour", int'(hour), 0);
    chk("day.wrap_dc", int'(day_carry), 1);
    tick_en = 1'b0;
    cyc(); check_model();
    chk("day.dc_drop", int'(day_carry), 0);

    // Directed vector table.
    for (int i = 0; i < 30; i++) begin
      apply_vec(tbl[i]);
      cyc();
      chk($sformatf("t%0d.sec", i), int'(sec), tbl[i].es);
      chk($sformatf("t%0d.min", i), int'(min), tbl[i].em);
      chk($sformatf("t%0d.hour", i), int'(hour), tbl[i].eh);
      chk($sformatf("t%0d.hdisp", i), int'(hour_disp), tbl[i].ehd);
      chk($sformatf("t%0d.pm", i), int'(pm), tbl[i].epm);
      chk($sformatf("t%0d.dc", i), int'(day_carry), tbl[i].edc);
      chk($sformatf("t%0d.alarm", i), int'(alarm_hit), tbl[i].eah);
      chk($sformatf("t%0d.lerr", i), int'(load_err), tbl[i].ele);
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      load = ($urandom_range(0, 15) == 0);
      load_sec = 6'($urandom_range(0, 62));
      load_min = 6'($urandom_range(0, 62));
      load_hour = 5'($urandom_range(0, 25));
      tick_en = 1'($urandom_range(0, 1));
      adj_sel = 2'($urandom_range(0, 3));
      adj_inc = 1'($urandom_range(0, 1));
      adj_dec = 1'($urandom_range(0, 1));
      mode_12h = 1'($urandom_range(0, 1));
      alarm_en = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) begin
        int nm;
        nm = (mt / 60 + 1) % 1440;
        alarm_hour = 5'(nm / 60);
        alarm_min = 6'(nm % 60);
      end
      cyc();
      check_model();
    end
    idle_in();

    // Small moduli: 10 s x 6 min x 4 h = 240-tick day.
    @(posedge clk); #1;
    chk("small.reset_sec", int'(sec_s), 0);
    rst_s = 1'b0;
    tick_s = 1'b1;
    for (int k = 1; k <= 240; k++) begin
      int t;
      @(posedge clk); #1;
      t = k % 240;
      chk("small.sec", int'(sec_s), t % 10);
      chk("small.min", int'(min_s), (t / 10) % 6);
      chk("small.hour", int'(hour_s), t / 60);
      chk("small.dc", int'(dc_s), (k == 240) ? 1 : 0);
    end
    tick_s = 1'b0;
    @(posedge clk); #1;
    chk("small.dc_drop", int'(dc_s), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
